// File: rtl/look.sv
// Pong pixel colour generator: registers the five object-region flags, then
// registers the prioritised 1-bit-per-channel RGB colour (two-cycle latency).
module look #(
  parameter logic [2:0] COLOR_BG   = 3'b000,
  parameter logic [2:0] COLOR_IW   = 3'b110,
  parameter logic [2:0] COLOR_WALL = 3'b010,
  parameter logic [2:0] COLOR_PAD2 = 3'b001,
  parameter logic [2:0] COLOR_PAD1 = 3'b100,
  parameter logic [2:0] COLOR_BALL = 3'b111,
  parameter logic [2:0] COLOR_HIT  = 3'b101
) (
  input  logic clk,
  input  logic rst_n,
  input  logic BRPad1,
  input  logic BRPad2,
  input  logic BRBall,
  input  logic BRWall,
  input  logic BRIW,
  output logic vga_red,
  output logic vga_green,
  output logic vga_blue
);

  // Stage-1 vector layout: {pad1, pad2, ball, wall, iw}
  logic [4:0] flags_d, flags_q;
  logic [2:0] rgb_d, rgb_q;
  logic       hit;

  always_comb begin
    flags_d = {BRPad1, BRPad2, BRBall, BRWall, BRIW};
  end

  // NOTE: every signal gets a default before the priority chain so no latch is inferred.
  always_comb begin
    rgb_d = COLOR_BG;
    hit   = flags_q[2] & (flags_q[4] | flags_q[3] | flags_q[1]);
    if (hit)             rgb_d = COLOR_HIT;
    else if (flags_q[2]) rgb_d = COLOR_BALL;
    else if (flags_q[4]) rgb_d = COLOR_PAD1;
    else if (flags_q[3]) rgb_d = COLOR_PAD2;
    else if (flags_q[1]) rgb_d = COLOR_WALL;
    else if (flags_q[0]) rgb_d = COLOR_IW;
  end

  // NOTE: non-blocking assignments so both stages sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
      rgb_q   <= '0;
    end else begin
      flags_q <= flags_d;
      rgb_q   <= rgb_d;
    end
  end

  assign {vga_red, vga_green, vga_blue} = rgb_q;

endmodule

// File: tb/tb_look.sv
// Scoreboard bench for look: the driver pushes the hand-computed colour due
// after each edge; a monitor pops one entry per edge and compares.
module tb_look;

  logic clk = 1'b0;
  logic rst_n;
  logic pad1, pad2, ball, wall, iw;
  logic vga_red, vga_green, vga_blue;

  always #20 clk = ~clk;

  look dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .BRPad1   (pad1),
    .BRPad2   (pad2),
    .BRBall   (ball),
    .BRWall   (wall),
    .BRIW     (iw),
    .vga_red  (vga_red),
    .vga_green(vga_green),
    .vga_blue (vga_blue)
  );

  typedef struct {
    logic       rst_n;
    logic [4:0] vec;   // {pad1, pad2, ball, wall, iw}
    logic [2:0] exp;   // colour this vector should produce two edges later
    string      name;
  } step_t;

  typedef struct {
    logic [2:0] exp;
    string      name;
  } sb_t;

  step_t steps[$];
  sb_t   sb[$];
  int    errors = 0;
  int    checks = 0;

  task automatic add(input logic r, input logic [4:0] v, input logic [2:0] e,
                     input string n, input int reps);
    step_t s;
    s.rst_n = r; s.vec = v; s.exp = e; s.name = n;
    for (int i = 0; i < reps; i++) steps.push_back(s);
  endtask

  task automatic check(input string n, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rgb=%b expected %b at %0t", n, act, exp, $time);
    end
  endtask

  // Monitor: one output pixel per edge, sampled 1 ns after the edge.
  always @(posedge clk) begin
    sb_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, {vga_red, vga_green, vga_blue}, e.exp);
    end
  end

  initial begin
    logic [2:0] s1_exp;
    sb_t        e;

    add(1'b0, 5'b00100, 3'b000, "reset_hold",      2);
    add(1'b1, 5'b00000, 3'b000, "bg_after_reset",  3);
    add(1'b1, 5'b00001, 3'b110, "iw",              3);
    add(1'b1, 5'b00010, 3'b010, "wall",            3);
    add(1'b1, 5'b00100, 3'b111, "ball",            3);
    add(1'b1, 5'b01000, 3'b001, "pad2",            3);
    add(1'b1, 5'b10000, 3'b100, "pad1",            3);
    add(1'b1, 5'b11100, 3'b101, "hit_pads",        2);
    add(1'b1, 5'b00110, 3'b101, "hit_wall",        2);
    add(1'b1, 5'b01100, 3'b101, "hit_pad2",        2);
    add(1'b1, 5'b10100, 3'b101, "hit_pad1",        2);
    add(1'b1, 5'b11000, 3'b100, "pad1_over_pad2",  2);
    add(1'b1, 5'b00011, 3'b010, "wall_over_iw",    2);
    add(1'b1, 5'b00101, 3'b111, "ball_iw_no_hit",  2);
    add(1'b1, 5'b01010, 3'b001, "pad2_over_wall",  2);
    add(1'b1, 5'b10001, 3'b100, "pad1_over_iw",    2);
    add(1'b1, 5'b11111, 3'b101, "all_flags",       2);
    for (int i = 0; i < 4; i++) begin
      add(1'b1, 5'b00100, 3'b111, "toggle_ball", 1);
      add(1'b1, 5'b00000, 3'b000, "toggle_bg",   1);
    end
    add(1'b1, 5'b10000, 3'b100, "stream_pad1",     3);
    add(1'b0, 5'b10000, 3'b100, "midstream_reset", 1);
    add(1'b1, 5'b10000, 3'b100, "pad1_return",     4);

    // s1_exp: colour implied by what stage 1 currently holds (zeroed stage 1 is black).
    s1_exp = 3'b000;
    foreach (steps[k]) begin
      @(negedge clk);
      rst_n = steps[k].rst_n;
      {pad1, pad2, ball, wall, iw} = steps[k].vec;
      e.name = steps[k].name;
      e.exp  = steps[k].rst_n ? s1_exp : 3'b000;
      sb.push_back(e);
      s1_exp = steps[k].rst_n ? steps[k].exp : 3'b000;
    end

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    if (checks < 12) begin
      errors++;
      $display("FAIL check_count: got %0d expected >= 12", checks);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
